section_normalizer: RTL and testbench
=====================================

// Module: section_normalizer
// PURPOSE
//  Downstream consumer of the per-section mean/stdev coefficient mux in the 4-way interleaved ADC path.
//  Tags each accepted sample with its ADC section (0..3) and drives adc_section to the mux.
//  Takes back the selected mean and gain, where gain = 1/stdev, and outputs a saturated, rounded value:
//  (x - mean) * gain.
//  Streaming valid/ready pipeline; saturation events are counted.
// PARAMETERS
//  DATA_W    12  unsigned ADC sample width
//  MEAN_FRAC 16  fractional bits of mean_in (ufix32_16, sample units)
//  GAIN_FRAC 24  fractional bits of gain_in (ufix32_24, reciprocal stdev)
//  OUT_W     16  signed output width
//  OUT_FRAC  8   fractional bits of out_data
// PORTS
//  clk          in   1       single clock
//  rst          in   1       synchronous reset, active-high
//  in_data      in   DATA_W  unsigned ADC sample
//  in_sync      in   1       qualifies in_valid; marks the sample as section 0
//  in_valid     in   1       sample valid
//  in_ready     out  1       sample accepted when in_valid & in_ready
//  adc_section  out  2       section of the stage-1 sample; drives the coefficient mux select
//  mean_in      in   32      mean returned by the mux for adc_section (combinational, same cycle)
//  gain_in      in   32      stdev/gain returned by the mux for adc_section
//  out_data     out  OUT_W   normalized sample, signed, OUT_FRAC fractional bits
//  out_section  out  2       section tag of out_data
//  out_sat      out  1       out_data was clipped
//  out_valid    out  1       output valid
//  out_ready    in   1       downstream accept
//  sat_clear    in   1       clears sat_count
//  sat_count    out  16      saturating count of accepted outputs with out_sat=1
// BEHAVIOUR
//  Reset: every valid flag = 0; section counter = 0; adc_section = 0; out_data = 0.
//   Also cleared: out_section = 0, out_sat = 0, sat_count = 0.
//   Reset mid-stream discards all in-flight samples; no output follows reset.
//  Stall = out_valid & ~out_ready. in_ready = ~stall.
//   On stall all four stages hold (global enable); no sample is lost or duplicated.
//   out_data, out_section and out_sat stay stable while out_valid & ~out_ready.
//  Section counter advances only on accept:
//   tag = in_sync ? 0 : cnt.
//   Next cnt = tag + 1 (mod 4, wraps 3 -> 0).
//   in_sync without in_valid is ignored.
//  Pipeline, 4 register stages. A sample accepted at edge N is on out_data after edge N+3, absent stalls.
//   S1: register x and tag. adc_section = S1 tag.
//       mean_in and gain_in are sampled at the S1 -> S2 advance.
//   S2: diff = ({x, MEAN_FRAC zeros}) - mean_in. Signed, 34 bits, exact. Register gain.
//   S3: prod = diff * $signed({1'b0, gain}). 67-bit signed, exact.
//   S4: SH = MEAN_FRAC + GAIN_FRAC - OUT_FRAC (32).
//       r = (prod + 2^(SH-1)) >>> SH, arithmetic; rounds half up.
//       Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//       out_sat = 1 if r was clipped.
//  Bubbles (stage valid = 0) advance freely; valid bits shift with data.
//  sat_count increments on each out_valid & out_ready & out_sat and holds at 16'hFFFF.
//   sat_clear zeroes it, with priority over a same-cycle increment.
//  gain_in = 0 gives out_data = 0, not saturated. mean_in above the sample range gives a negative result.
// STRUCTURE
//  Shared package norm_pkg holds:
//   localparams DATA_W, MEAN_FRAC, GAIN_FRAC, OUT_W, OUT_FRAC, SH;
//   section encoding SEC_0..SEC_3 (2'b00..2'b11), shared with the coefficient mux.
//  One sub-module: norm_round_sat (S4 combinational round/shift/clip). Instantiated once.
//  Top holds the handshake, section counter, S1-S3 registers and sat_count.
// TESTING
//  1. x=2048, mean=2048<<16, gain=1<<24 -> out_data=0, out_sat=0, out_valid 4 regs after accept.
//  2. x=2100, mean=2048<<16, gain=1<<24 -> 13312.
//     x=1000, mean=1100<<16, gain=1<<23 -> -12800.
//  3. x=4095, mean=0, gain=16<<24 -> 32767, out_sat=1, sat_count=1.
//     x=0, mean=4095<<16, gain=1<<24 -> -32768, sat_count=2.
//     Then sat_clear -> sat_count=0.
//  4. 6 back-to-back samples, in_sync on the 1st -> out_section 0,1,2,3,0,1.
//     in_sync on the 3rd sample -> 0,1,0,1,2,3.
//  5. Continuous input, out_ready low 5 cycles -> in_ready low during stall.
//     Output sequence identical to the unstalled reference model; no drops or duplicates.
//  6. rst asserted with 3 samples in flight -> out_valid=0 and sat_count=0 the next cycle.
//     First output after reset is the first post-reset sample, tagged section 0.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared constants and section encoding for the ADC normalizer path.
// No logic; widths and fixed-point formats used by the normalizer and the coefficient mux.
// Section encoding SEC_0..SEC_3 must match the coefficient mux select decode.
package norm_pkg;

   localparam int DATA_W    = 12;   // unsigned ADC sample width
   localparam int MEAN_FRAC = 16;   // mean_in is ufix32_16
   localparam int GAIN_FRAC = 24;   // gain_in is ufix32_24
   localparam int OUT_W     = 16;   // signed output width
   localparam int OUT_FRAC  = 8;    // output fractional bits

   // Product carries MEAN_FRAC + GAIN_FRAC fractional bits; drop down to OUT_FRAC.
   localparam int SH        = MEAN_FRAC + GAIN_FRAC - OUT_FRAC;

   localparam int COEF_W    = 32;
   // x*2^16 (28 bits unsigned) minus a 32-bit mean needs 33 bits + sign.
   localparam int DIFF_W    = 34;
   // 34-bit signed diff times 33-bit signed (zero-extended) gain.
   localparam int PROD_W    = DIFF_W + COEF_W + 1;

   typedef enum logic [1:0] {
      SEC_0 = 2'b00,
      SEC_1 = 2'b01,
      SEC_2 = 2'b10,
      SEC_3 = 2'b11
   } sec_t;

   // Next section in the 4-way interleave, wrapping 3 -> 0.
   function automatic sec_t sec_next(input sec_t s);
      return sec_t'(s + 2'd1);
   endfunction

endpackage

// File: rtl/section_normalizer_if.sv
// Sample-in / normalized-out streaming bundle for the section normalizer.
// Ports: in_data/in_sync/in_valid -> in_ready ; out_data/out_section/out_sat/out_valid -> out_ready.
// slave = normalizer view, master = producer/consumer view driving samples and out_ready.
interface section_normalizer_if;
   import norm_pkg::*;

   logic [DATA_W-1:0]       in_data;
   logic                    in_sync;
   logic                    in_valid;
   logic                    in_ready;

   logic signed [OUT_W-1:0] out_data;
   logic [1:0]              out_section;
   logic                    out_sat;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, in_sync, in_valid, out_ready,
      input  in_ready, out_data, out_section, out_sat, out_valid
   );

   modport slave (
      input  in_data, in_sync, in_valid, out_ready,
      output in_ready, out_data, out_section, out_sat, out_valid
   );

endinterface

// File: rtl/norm_round_sat.sv
// Final-stage round/shift/clip of the normalized product (purely combinational).
// Ports: prod (PROD_W signed, SH+OUT_FRAC... fractional bits) -> data (OUT_W signed), sat (clip flag).
// No state, no handshake; the parent registers the result as its last stage.
module norm_round_sat
   import norm_pkg::*;
(
   input  logic signed [PROD_W-1:0] prod,
   output logic signed [OUT_W-1:0]  data,
   output logic                     sat
);

   // 2^(SH-1): adding it before the arithmetic shift rounds half up.
   localparam logic signed [PROD_W-1:0] HALF  =
      {{(PROD_W-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
   // Output range limits, sign-extended to the product width.
   localparam logic signed [PROD_W-1:0] MAX_V =
      {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] MIN_V =
      {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [PROD_W-1:0] sum;
   logic signed [PROD_W-1:0] shifted;

   // |prod| < 2^64, so adding HALF cannot overflow PROD_W bits.
   assign sum     = prod + HALF;
   assign shifted = sum >>> SH;

   always_comb begin
      data = '0;
      sat  = 1'b0;
      if (shifted > MAX_V) begin
         data = {1'b0, {(OUT_W-1){1'b1}}};
         sat  = 1'b1;
      end else if (shifted < MIN_V) begin
         data = {1'b1, {(OUT_W-1){1'b0}}};
         sat  = 1'b1;
      end else begin
         data = shifted[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/section_normalizer.sv
// Tags ADC samples with their interleave section and outputs (x - mean) * gain, rounded and clipped.
// Latency: 4 register stages, sample accepted at edge N appears after edge N+3; sat_count tracks clips.
// Backpressure: global stall when out_valid & ~out_ready; all stages hold and in_ready drops.
// Ports: clk, rst (sync, active-high); bus (slave stream); adc_section -> mux, mean_in/gain_in <- mux;
//        sat_clear -> zero sat_count; sat_count = saturating count of accepted clipped outputs.
module section_normalizer
   import norm_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   section_normalizer_if.slave bus,
   output logic [1:0]          adc_section,
   input  logic [COEF_W-1:0]   mean_in,
   input  logic [COEF_W-1:0]   gain_in,
   input  logic                sat_clear,
   output logic [15:0]         sat_count
);

   logic en;
   logic accept;
   sec_t cnt;
   sec_t tag;

   // Stage 1: raw sample and its section
   logic                     s1_vld;
   logic [DATA_W-1:0]        s1_x;
   sec_t                     s1_tag;

   // Stage 2: mean-removed sample and the matching gain
   logic                     s2_vld;
   logic signed [DIFF_W-1:0] s2_diff;
   logic [COEF_W-1:0]        s2_gain;
   sec_t                     s2_tag;

   // Stage 3: full-precision product
   logic                     s3_vld;
   logic signed [PROD_W-1:0] s3_prod;
   sec_t                     s3_tag;

   logic signed [DIFF_W-1:0] diff_c;
   logic signed [PROD_W-1:0] prod_c;
   logic signed [OUT_W-1:0]  rs_data;
   logic                     rs_sat;

   // A single enable freezes the whole pipe; bubbles still move when not stalled.
   assign en           = ~(bus.out_valid & ~bus.out_ready);
   assign bus.in_ready = en;
   assign accept       = bus.in_valid & en;

   // in_sync forces the sample onto section 0 and restarts the interleave from there.
   assign tag          = bus.in_sync ? SEC_0 : cnt;

   // The coefficient mux looks up the stage-1 sample's section; its answer is
   // captured in the same cycle the sample moves into stage 2.
   assign adc_section  = s1_tag;

   // Sample aligned to the mean's binary point, then the mean removed; exact in 34 bits.
   assign diff_c = $signed({{(DIFF_W-DATA_W-MEAN_FRAC){1'b0}}, s1_x, {MEAN_FRAC{1'b0}}})
                 - $signed({{(DIFF_W-COEF_W){1'b0}}, mean_in});

   // Gain is unsigned, so it is zero-extended; the low PROD_W bits of the product are exact.
   assign prod_c = $signed({{(PROD_W-DIFF_W){s2_diff[DIFF_W-1]}}, s2_diff})
                 * $signed({{(PROD_W-COEF_W){1'b0}}, s2_gain});

   norm_round_sat u_round_sat (
      .prod (s3_prod),
      .data (rs_data),
      .sat  (rs_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt             <= SEC_0;
         s1_vld          <= 1'b0;
         s1_x            <= '0;
         s1_tag          <= SEC_0;
         s2_vld          <= 1'b0;
         s2_diff         <= '0;
         s2_gain         <= '0;
         s2_tag          <= SEC_0;
         s3_vld          <= 1'b0;
         s3_prod         <= '0;
         s3_tag          <= SEC_0;
         bus.out_valid   <= 1'b0;
         bus.out_data    <= '0;
         bus.out_section <= 2'b00;
         bus.out_sat     <= 1'b0;
         sat_count       <= 16'd0;
      end else begin
         if (accept) begin
            cnt <= sec_next(tag);
         end

         if (en) begin
            // Valid bits always shift; payload only loads behind a valid so that
            // adc_section and the output hold their last real values across bubbles.
            s1_vld        <= bus.in_valid;
            s2_vld        <= s1_vld;
            s3_vld        <= s2_vld;
            bus.out_valid <= s3_vld;

            if (bus.in_valid) begin
               s1_x   <= bus.in_data;
               s1_tag <= tag;
            end
            if (s1_vld) begin
               s2_diff <= diff_c;
               s2_gain <= gain_in;
               s2_tag  <= s1_tag;
            end
            if (s2_vld) begin
               s3_prod <= prod_c;
               s3_tag  <= s2_tag;
            end
            if (s3_vld) begin
               bus.out_data    <= rs_data;
               bus.out_section <= s3_tag;
               bus.out_sat     <= rs_sat;
            end
         end

         // Clear wins over a coincident increment; the count sticks at all-ones.
         if (sat_clear) begin
            sat_count <= 16'd0;
         end else if (bus.out_valid & bus.out_ready & bus.out_sat & (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_section_normalizer.sv
module tb_section_normalizer;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  sec;
      logic        sat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  adc_section;
   logic [31:0] mean_in;
   logic [31:0] gain_in;
   logic        sat_clear;
   logic [15:0] sat_count;

   section_normalizer_if bus ();

   section_normalizer dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .adc_section (adc_section),
      .mean_in     (mean_in),
      .gain_in     (gain_in),
      .sat_clear   (sat_clear),
      .sat_count   (sat_count)
   );

   always #5 clk = ~clk;

   // Coefficient mux model: combinational lookup by section.
   logic [31:0] mean_tbl [4];
   logic [31:0] gain_tbl [4];
   always_comb begin
      mean_in = mean_tbl[adc_section];
      gain_in = gain_tbl[adc_section];
   end

   exp_t q[$];
   int   obs_sec[$];
   int   obs_dat[$];
   int   total = 0;
   int   bad = 0;
   int   mcnt = 0;
   int   msat = 0;
   bit   rnd_rdy = 1'b0;
   int   low_cnt = 0;

   task automatic chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=timeout/unexpected required=none", name);
   endtask

   // Reference: exact rational arithmetic on wide integers, then round and clip.
   function automatic exp_t ref_out(input int xs, input logic [31:0] m,
                                    input logic [31:0] g, input int sec);
      longint             d;
      logic signed [127:0] p;
      logic signed [127:0] gg;
      logic signed [127:0] r;
      exp_t               e;
      d  = longint'(xs) * 65536 - longint'({32'd0, m});
      p  = d;
      gg = $signed({96'd0, g});
      p  = p * gg;
      r  = (p + (128'sd1 <<< 31)) >>> 32;
      e.sec = 2'(sec);
      if (r > 32767) begin
         e.data = 16'h7FFF;
         e.sat  = 1'b1;
      end else if (r < -32768) begin
         e.data = 16'h8000;
         e.sat  = 1'b1;
      end else begin
         e.data = r[15:0];
         e.sat  = 1'b0;
      end
      return e;
   endfunction

   task automatic push_exp(input logic [11:0] xs, input logic sync);
      int tag;
      tag  = sync ? 0 : mcnt;
      mcnt = (tag + 1) % 4;
      q.push_back(ref_out(int'(xs), mean_tbl[tag], gain_tbl[tag], tag));
   endtask

   task automatic drive_rdy();
      if (low_cnt > 0) begin
         bus.out_ready = 1'b0;
         low_cnt--;
      end else if (rnd_rdy) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
         bus.out_ready = 1'b1;
      end
   endtask

   task automatic send(input logic [11:0] xs, input logic sync);
      int guard = 0;
      bus.in_data  = xs;
      bus.in_sync  = sync;
      bus.in_valid = 1'b1;
      drive_rdy();
      @(negedge clk);
      while (!bus.in_ready && guard < 200) begin
         @(posedge clk); #1;
         drive_rdy();
         @(negedge clk);
         guard++;
      end
      if (!bus.in_ready) fail("send_timeout");
      else push_exp(xs, sync);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      bus.in_sync  = 1'b0;
      repeat (n) begin
         drive_rdy();
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int guard = 0;
      bus.in_valid = 1'b0;
      while (q.size() != 0 && guard < 500) begin
         drive_rdy();
         @(posedge clk); #1;
         guard++;
      end
      if (q.size() != 0) fail("drain_timeout");
      idle(2);
   endtask

   task automatic set_tbl(input logic [31:0] m, input logic [31:0] g);
      for (int i = 0; i < 4; i++) begin
         mean_tbl[i] = m;
         gain_tbl[i] = g;
      end
   endtask

   // Monitor / scoreboard: runs on the falling edge, away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            chk("sat_count", longint'(sat_count), longint'(msat));
            chk("in_ready", longint'(bus.in_ready),
                longint'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid) begin
               if (q.size() == 0) begin
                  fail("unexpected_output");
               end else begin
                  e = q[0];
                  chk("out_data", longint'($signed(bus.out_data)), longint'($signed(e.data)));
                  chk("out_section", longint'(bus.out_section), longint'(e.sec));
                  chk("out_sat", longint'(bus.out_sat), longint'(e.sat));
                  if (bus.out_ready) begin
                     void'(q.pop_front());
                     obs_sec.push_back(int'(bus.out_section));
                     obs_dat.push_back(int'($signed(bus.out_data)));
                     if (e.sat && msat < 65535) msat++;
                  end
               end
            end
            if (sat_clear) msat = 0;
         end
      end
   end

   initial begin
      int k;
      int exp_a[6];
      int exp_b[6];
      exp_a = '{0, 1, 2, 3, 0, 1};
      exp_b = '{0, 1, 0, 1, 2, 3};

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_sync   = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      sat_clear     = 1'b0;
      set_tbl(32'd2048 << 16, 32'd1 << 24);
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_out_data", longint'(bus.out_data), 0);
      chk("rst_out_section", longint'(bus.out_section), 0);
      chk("rst_out_sat", longint'(bus.out_sat), 0);
      chk("rst_adc_section", longint'(adc_section), 0);
      chk("rst_sat_count", longint'(sat_count), 0);
      rst = 1'b0;

      // 1: zero-mean sample, latency
      send(12'd2048, 1'b1);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.out_valid && k < 20);
      chk("latency", k, 4);
      drain();

      // 2: positive and negative results with known constants
      obs_dat.delete();
      send(12'd2100, 1'b0);
      drain();
      set_tbl(32'd1100 << 16, 32'd1 << 23);
      send(12'd1000, 1'b0);
      drain();
      chk("t2_count", obs_dat.size(), 2);
      if (obs_dat.size() == 2) begin
         chk("t2_pos", obs_dat[0], 13312);
         chk("t2_neg", obs_dat[1], -12800);
      end

      // 3: saturation both ways, counting, clear
      set_tbl(32'd0, 32'd16 << 24);
      send(12'd4095, 1'b0);
      drain();
      set_tbl(32'd4095 << 16, 32'd1 << 24);
      send(12'd0, 1'b0);
      drain();
      chk("t3_sat_count2", longint'(sat_count), 2);
      sat_clear = 1'b1;
      @(posedge clk); #1;
      sat_clear = 1'b0;
      chk("t3_sat_cleared", longint'(sat_count), 0);

      // 4: section tagging
      set_tbl(32'd2048 << 16, 32'd1 << 24);
      obs_sec.delete();
      for (int i = 0; i < 6; i++) send(12'(1000 + i), (i == 0));
      drain();
      chk("t4a_count", obs_sec.size(), 6);
      if (obs_sec.size() == 6)
         for (int i = 0; i < 6; i++) chk("t4a_section", obs_sec[i], exp_a[i]);
      send(12'd10, 1'b0);
      send(12'd11, 1'b0);
      drain();
      obs_sec.delete();
      for (int i = 0; i < 6; i++) send(12'(2000 + i), (i == 2));
      drain();
      chk("t4b_count", obs_sec.size(), 6);
      if (obs_sec.size() == 6)
         for (int i = 0; i < 6; i++) chk("t4b_section", obs_sec[i], exp_b[i]);

      // 5a: continuous input with a 5-cycle out_ready drop
      for (int i = 0; i < 4; i++) begin
         mean_tbl[i] = {4'd0, 12'($urandom_range(0, 4095)), 16'($urandom)};
         gain_tbl[i] = $urandom >> $urandom_range(6, 12);
      end
      gain_tbl[3] = 32'd0;
      mean_tbl[2] = 32'hF000_0000 | $urandom;
      for (int i = 0; i < 20; i++) begin
         if (i == 6) low_cnt = 5;
         send(12'($urandom), ($urandom_range(0, 7) == 0));
      end
      drain();

      // 5b: randomized traffic, random gaps and backpressure
      rnd_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         send(12'($urandom), ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();
      rnd_rdy = 1'b0;

      // 6: reset with samples in flight
      set_tbl(32'd0, 32'd16 << 24);
      send(12'd4095, 1'b0);
      drain();
      set_tbl(32'd2048 << 16, 32'd1 << 24);
      send(12'd100, 1'b0);
      send(12'd200, 1'b0);
      send(12'd300, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      q.delete();
      mcnt = 0;
      msat = 0;
      chk("t6_out_valid", longint'(bus.out_valid), 0);
      chk("t6_sat_count", longint'(sat_count), 0);
      rst = 1'b0;
      idle(6);
      obs_sec.delete();
      obs_dat.delete();
      send(12'd2148, 1'b0);
      drain();
      chk("t6_count", obs_sec.size(), 1);
      if (obs_sec.size() == 1) begin
         chk("t6_section", obs_sec[0], 0);
         chk("t6_data", obs_dat[0], 25600);
      end

      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
